// File: rtl/type_r_sequencer.sv
// Multi-cycle control sequencer for R-type, lw and sw instructions with registered outputs.
// Optional retired-instruction counter and `retired` port are enabled by defining CTRL_CONTADOR_EN.
module type_r_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instruccion,
  input  logic             mem_ack,
  output logic             BR_En,
  output logic [2:0]       AluC,
  output logic             EnR,
  output logic             EnW,
  output logic             Mux1,
  output logic             done,
  output logic             err
`ifdef CTRL_CONTADOR_EN
  ,
  output logic [CNT_W-1:0] retired
`endif
);

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExec,
    StMem,
    StWb,
    StErr
  } state_e;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  state_e     state_q, state_d;
  logic [5:0] op_q, funct_q;

  logic       ready_q, ready_d;
  logic       br_q, br_d;
  logic [2:0] aluc_q, aluc_d;
  logic       enr_q, enr_d;
  logic       enw_q, enw_d;
  logic       mux1_q, mux1_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       handshake;
  logic       is_r, is_lw, is_sw;
  logic       funct_ok;
  logic       legal;
  logic [2:0] alu_code;

  assign handshake = instr_valid && ready_q;

  // Decode works only on the latched copy, so the source may change the word mid-operation.
  always_comb begin
    is_r     = (op_q == OpRType);
    is_lw    = (op_q == OpLw);
    is_sw    = (op_q == OpSw);
    funct_ok = 1'b0;
    alu_code = 3'b000;
    if (is_lw || is_sw) begin
      alu_code = 3'b010;
    end else if (is_r) begin
      funct_ok = 1'b1;
      case (funct_q)
        6'b100000: alu_code = 3'b010;
        6'b100010: alu_code = 3'b110;
        6'b100100: alu_code = 3'b000;
        6'b100101: alu_code = 3'b001;
        6'b101010: alu_code = 3'b111;
        default:   funct_ok = 1'b0;
      endcase
    end
    legal = is_lw || is_sw || funct_ok;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (handshake) state_d = StDecode;
      StDecode: state_d = legal ? StExec : StErr;
      StExec:   state_d = is_r ? StWb : StMem;
      StMem: begin
        if (mem_ack) state_d = is_lw ? StWb : StIdle;
      end
      StWb:     state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    ready_d = (state_d == StIdle);
    br_d    = (state_d == StWb);
    mux1_d  = (state_d == StWb) && is_lw;
    enr_d   = (state_d == StMem) && is_lw;
    enw_d   = (state_d == StMem) && is_sw;
    aluc_d  = (state_d == StExec) ? alu_code : aluc_q;
    done_d  = (state_q == StWb) || ((state_q == StMem) && mem_ack && is_sw);
    err_d   = (state_d == StErr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 6'b000000;
      funct_q <= 6'b000000;
      ready_q <= 1'b0;
      br_q    <= 1'b0;
      aluc_q  <= 3'b000;
      enr_q   <= 1'b0;
      enw_q   <= 1'b0;
      mux1_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (handshake) begin
        op_q    <= instruccion[31:26];
        funct_q <= instruccion[5:0];
      end
      ready_q <= ready_d;
      br_q    <= br_d;
      aluc_q  <= aluc_d;
      enr_q   <= enr_d;
      enw_q   <= enw_d;
      mux1_q  <= mux1_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign instr_ready = ready_q;
  assign BR_En       = br_q;
  assign AluC        = aluc_q;
  assign EnR         = enr_q;
  assign EnW         = enw_q;
  assign Mux1        = mux1_q;
  assign done        = done_q;
  assign err         = err_q;

`ifdef CTRL_CONTADOR_EN
  logic [CNT_W-1:0] retired_q;

  // Updates on the same edge that raises done, so the count already includes that instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (done_d) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;
`endif

endmodule
